// File: rtl/change_dispenser.sv
// change_dispenser: payout side of the vending machine coin interface.
// Breaks a change amount greedily into 20/10/5/1 coins against per-denomination
// inventory counters and hands them one at a time to the coin ejector.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, amount             dispense request and value (sampled when idle)
//   coin_req, coin_sel        coin request / one-hot denomination to ejector
//   coin_ack                  ejector released the requested coin
//   restock, restock_sel/qty  inventory add while idle (one-hot select)
//   busy, done                activity flag, one-cycle completion pulse
//   short_change, timeout_err sticky payout status, cleared by next start
//   remaining                 amount still owed
//   inv_empty                 per-denomination inventory == 0
// Denomination bit mapping everywhere: bit0=1, bit1=5, bit2=10, bit3=20.
module change_dispenser #(
  parameter int unsigned AMT_W       = 7,
  parameter int unsigned INV_W       = 6,
  parameter int unsigned INIT_CNT1   = 20,
  parameter int unsigned INIT_CNT5   = 20,
  parameter int unsigned INIT_CNT10  = 20,
  parameter int unsigned INIT_CNT20  = 20,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             coin_ack,
  input  logic             restock,
  input  logic [3:0]       restock_sel,
  input  logic [INV_W-1:0] restock_qty,
  output logic             coin_req,
  output logic [3:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             short_change,
  output logic             timeout_err,
  output logic [AMT_W-1:0] remaining,
  output logic [3:0]       inv_empty
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int unsigned DEN [4] = '{1, 5, 10, 20};

  logic [2:0]       state, state_n;
  logic [INV_W-1:0] inv [4];
  logic [INV_W-1:0] inv_n [4];
  logic [AMT_W-1:0] remaining_n;
  logic             coin_req_n, short_n, tmo_n;
  logic [3:0]       coin_sel_n;
  logic [15:0]      tcnt, tcnt_n;
  logic [15:0]      gcnt, gcnt_n;
  logic [3:0]       pick;
  logic             found;
  int unsigned      cur_val;
  logic [INV_W:0]   sum;

  // Greedy choice: scan from the largest denomination down.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!found && inv[2'(3 - k)] != '0 && 32'(remaining) >= DEN[2'(3 - k)]) begin
        pick[2'(3 - k)] = 1'b1;
        found           = 1'b1;
      end
    end
  end

  always_comb begin
    cur_val = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (coin_sel[k]) cur_val = DEN[k];
    end
  end

  always_comb begin
    state_n     = state;
    inv_n       = inv;
    remaining_n = remaining;
    coin_req_n  = coin_req;
    coin_sel_n  = coin_sel;
    short_n     = short_change;
    tmo_n       = timeout_err;
    tcnt_n      = tcnt;
    gcnt_n      = gcnt;
    sum         = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          remaining_n = amount;
          short_n     = 1'b0;
          tmo_n       = 1'b0;
          state_n     = S_SELECT;
        end
        if (restock && $onehot(restock_sel)) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (restock_sel[k]) begin
              sum      = {1'b0, inv[k]} + {1'b0, restock_qty};
              inv_n[k] = sum[INV_W] ? '1 : sum[INV_W-1:0];
            end
          end
        end
      end
      S_SELECT: begin
        if (remaining == '0) begin
          state_n = S_DONE;
        end else if (found) begin
          coin_req_n = 1'b1;
          coin_sel_n = pick;
          tcnt_n     = '0;
          state_n    = S_ISSUE;
        end else begin
          short_n = 1'b1;
          state_n = S_DONE;
        end
      end
      S_ISSUE: begin
        // An ack on the same edge as the final timeout cycle still counts.
        if (coin_ack) begin
          remaining_n = remaining - AMT_W'(cur_val);
          for (int unsigned k = 0; k < 4; k++) begin
            if (coin_sel[k]) inv_n[k] = inv[k] - 1'b1;
          end
          coin_req_n = 1'b0;
          coin_sel_n = '0;
          gcnt_n     = '0;
          state_n    = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
        end else if (32'(tcnt) + 32'd1 >= ACK_TIMEOUT) begin
          coin_req_n = 1'b0;
          coin_sel_n = '0;
          tmo_n      = 1'b1;
          state_n    = S_DONE;
        end else begin
          tcnt_n = tcnt + 16'd1;
        end
      end
      S_GAP: begin
        if (32'(gcnt) + 32'd1 >= GAP_CYCLES) state_n = S_SELECT;
        else gcnt_n = gcnt + 16'd1;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      inv[0]       <= INV_W'(INIT_CNT1);
      inv[1]       <= INV_W'(INIT_CNT5);
      inv[2]       <= INV_W'(INIT_CNT10);
      inv[3]       <= INV_W'(INIT_CNT20);
      inv_empty    <= {INIT_CNT20 == 0, INIT_CNT10 == 0, INIT_CNT5 == 0, INIT_CNT1 == 0};
      remaining    <= '0;
      coin_req     <= 1'b0;
      coin_sel     <= '0;
      short_change <= 1'b0;
      timeout_err  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tcnt         <= '0;
      gcnt         <= '0;
    end else begin
      state        <= state_n;
      for (int unsigned k = 0; k < 4; k++) begin
        inv[k]       <= inv_n[k];
        inv_empty[k] <= (inv_n[k] == '0);
      end
      remaining    <= remaining_n;
      coin_req     <= coin_req_n;
      coin_sel     <= coin_sel_n;
      short_change <= short_n;
      timeout_err  <= tmo_n;
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
      tcnt         <= tcnt_n;
      gcnt         <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser. Instance 0 uses default parameters;
// instance 1 starts with no 1-coins, a single 20-coin and a short ack timeout.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic [1:0] rst, start, coin_ack, restock;
  logic [6:0] amount [2];
  logic [3:0] restock_sel [2];
  logic [5:0] restock_qty [2];
  logic [1:0] coin_req, busy, done, short_change, timeout_err;
  logic [3:0] coin_sel [2];
  logic [6:0] remaining [2];
  logic [3:0] inv_empty [2];

  int errors = 0;
  int checks = 0;

  int         n_coins, n_done, hi_max, first_req;
  logic [3:0] seq_sel [32];
  logic [6:0] seq_rem [32];
  int         gaps [32];

  always #5 clk = ~clk;

  change_dispenser u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .amount(amount[0]),
    .coin_ack(coin_ack[0]), .restock(restock[0]), .restock_sel(restock_sel[0]),
    .restock_qty(restock_qty[0]), .coin_req(coin_req[0]), .coin_sel(coin_sel[0]),
    .busy(busy[0]), .done(done[0]), .short_change(short_change[0]),
    .timeout_err(timeout_err[0]), .remaining(remaining[0]), .inv_empty(inv_empty[0])
  );

  change_dispenser #(.INIT_CNT1(0), .INIT_CNT20(1), .ACK_TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .amount(amount[1]),
    .coin_ack(coin_ack[1]), .restock(restock[1]), .restock_sel(restock_sel[1]),
    .restock_qty(restock_qty[1]), .coin_req(coin_req[1]), .coin_sel(coin_sel[1]),
    .busy(busy[1]), .done(done[1]), .short_change(short_change[1]),
    .timeout_err(timeout_err[1]), .remaining(remaining[1]), .inv_empty(inv_empty[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a payout on instance d and follows it until busy drops.
  // ack_en: raise coin_ack in the second cycle coin_req is high.
  // poke_kind 1: start(amount=1) at poke_cyc; 2: restock 1-coins qty 2 at poke_cyc.
  task automatic payout(input int d, input int amt, input bit ack_en,
                        input int poke_cyc, input int poke_kind);
    int lowcnt, hicnt;
    bit prev, fin;
    n_coins = 0; n_done = 0; hi_max = 0; first_req = -1;
    lowcnt = 0; hicnt = 0; prev = 1'b0; fin = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    amount[d] = 7'(amt);
    @(negedge clk);
    start[d] = 1'b0;
    amount[d] = 7'd0;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      if (done[d]) n_done++;
      if (coin_req[d]) begin
        if (!prev) begin
          if (first_req < 0) first_req = cyc;
          if (n_coins < 32) begin
            seq_sel[n_coins] = coin_sel[d];
            gaps[n_coins] = lowcnt;
          end
          n_coins++;
          hicnt = 0;
        end
        hicnt++;
        if (hicnt > hi_max) hi_max = hicnt;
        if (ack_en && hicnt == 2) coin_ack[d] = 1'b1;
      end else begin
        if (prev) begin
          coin_ack[d] = 1'b0;
          if (n_coins <= 32) seq_rem[n_coins-1] = remaining[d];
          lowcnt = 0;
        end
        lowcnt++;
      end
      prev = coin_req[d];
      if (!busy[d]) begin
        fin = 1'b1;
      end else begin
        start[d]       = (poke_kind == 1 && cyc == poke_cyc);
        amount[d]      = 7'd1;
        restock[d]     = (poke_kind == 2 && cyc == poke_cyc);
        restock_sel[d] = 4'b0001;
        restock_qty[d] = 6'd2;
        @(negedge clk);
      end
    end
    start[d] = 1'b0; restock[d] = 1'b0; coin_ack[d] = 1'b0;
    if (!fin) check("payout_bound", 32'd0, 32'd1);
  endtask

  task automatic do_restock(input int d, input logic [3:0] sel, input logic [5:0] qty);
    @(negedge clk);
    restock[d] = 1'b1; restock_sel[d] = sel; restock_qty[d] = qty;
    @(negedge clk);
    restock[d] = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_sel [6];
    logic [6:0] exp_rem [6];
    int total, bad, dsum;
    rst = 2'b11; start = '0; coin_ack = '0; restock = '0;
    for (int i = 0; i < 2; i++) begin
      amount[i] = '0; restock_sel[i] = '0; restock_qty[i] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check("rst_busy0", busy[0], 0);
    check("rst_req0", coin_req[0], 0);
    check("rst_rem0", remaining[0], 0);
    check("rst_flags0", {done[0], short_change[0], timeout_err[0]}, 0);
    check("rst_empty0", inv_empty[0], 4'b0000);
    check("rst_empty1", inv_empty[1], 4'b0001);
    rst = 2'b00;

    // 38 = 20 + 10 + 5 + 1 + 1 + 1
    exp_sel = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    exp_rem = '{7'd18, 7'd8, 7'd3, 7'd2, 7'd1, 7'd0};
    payout(0, 38, 1'b1, -1, 0);
    check("t38_ncoins", n_coins, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t38_sel%0d", i), seq_sel[i], exp_sel[i]);
      check($sformatf("t38_rem%0d", i), seq_rem[i], exp_rem[i]);
    end
    // coin_req stays low for the GAP cycles plus the SELECT cycle
    for (int i = 1; i < 6; i++) check($sformatf("t38_gap%0d", i), gaps[i], 5);
    check("t38_first_req", first_req, 1);
    check("t38_done", n_done, 1);
    check("t38_short", short_change[0], 0);

    // Second start mid-payout must not resample amount.
    payout(0, 38, 1'b1, 3, 1);
    check("t38b_ncoins", n_coins, 6);
    check("t38b_last_sel", seq_sel[5], 4'b0001);
    check("t38b_done", n_done, 1);
    check("t38b_rem", remaining[0], 0);

    // Zero amount: done in the cycle after SELECT, no coin.
    payout(0, 0, 1'b1, -1, 0);
    check("t0_ncoins", n_coins, 0);
    check("t0_done", n_done, 1);

    // Reset while a coin request is outstanding.
    @(negedge clk);
    start[0] = 1'b1; amount[0] = 7'd10;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 10 && !coin_req[0]; i++) @(negedge clk);
    check("rst_mid_req_seen", coin_req[0], 1);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("rst_mid_req", coin_req[0], 0);
    check("rst_mid_busy", busy[0], 0);
    check("rst_mid_rem", remaining[0], 0);
    check("rst_mid_empty", inv_empty[0], 4'b0000);
    dsum = int'(done[0]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dsum += int'(done[0]);
    end
    check("rst_mid_nodone", dsum, 0);

    // Instance 1: single 20-coin, no 1-coins.
    payout(1, 45, 1'b1, -1, 0);
    check("t45_ncoins", n_coins, 4);
    check("t45_sel", {seq_sel[0], seq_sel[1], seq_sel[2], seq_sel[3]}, 16'h8442);
    check("t45_rem", {seq_rem[0], seq_rem[1], seq_rem[2], seq_rem[3]}, {7'd25, 7'd15, 7'd5, 7'd0});
    check("t45_empty", inv_empty[1], 4'b1001);
    payout(1, 20, 1'b1, -1, 0);
    check("t20_ncoins", n_coins, 2);
    check("t20_sel", {seq_sel[0], seq_sel[1]}, 8'h44);

    // 7 with no 1-coins: one 5, then short by 2. Restock while busy is dropped.
    payout(1, 7, 1'b1, 2, 2);
    check("t7_ncoins", n_coins, 1);
    check("t7_sel", seq_sel[0], 4'b0010);
    check("t7_short", short_change[1], 1);
    check("t7_rem", remaining[1], 2);
    check("t7_done", n_done, 1);
    check("t7_empty", inv_empty[1], 4'b1001);

    // Ejector never acks: request held ACK_TIMEOUT cycles, then abort.
    payout(1, 5, 1'b0, -1, 0);
    check("tmo_short_cleared", short_change[1], 0);
    check("tmo_err", timeout_err[1], 1);
    check("tmo_hi", hi_max, 8);
    check("tmo_sel", seq_sel[0], 4'b0010);
    check("tmo_rem", remaining[1], 5);
    check("tmo_done", n_done, 1);
    check("tmo_empty", inv_empty[1], 4'b1001);

    // Restock: non-one-hot ignored, then 3 + 63 saturates at 63.
    do_restock(1, 4'b1001, 6'd5);
    check("rs_nonhot", inv_empty[1], 4'b1001);
    do_restock(1, 4'b0001, 6'd3);
    check("rs_add", inv_empty[1], 4'b1000);
    do_restock(1, 4'b0001, 6'd63);
    // Drain 1-coins with payouts of 4: 63 coins means 15 full payouts
    // and a 16th that issues 3 and ends short by 1.
    total = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      payout(1, 4, 1'b1, -1, 0);
      total += n_coins;
      if (i < 15 && short_change[1]) bad++;
    end
    check("rs_total", total, 63);
    check("rs_early_short", bad, 0);
    check("rs_last_short", short_change[1], 1);
    check("rs_last_rem", remaining[1], 1);
    check("rs_empty", inv_empty[1][0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
